// File: rtl/quadro_tabuleiro.sv
// Double-buffered 8x8 frame store feeding the LED matrix driver, with a clipped
// 4x4 piece overlay, blink control and a registered collision flag.
module quadro_tabuleiro #(
    parameter int unsigned PISCA_LOG2 = 22
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        escrita_valida,
    input  logic [2:0]  escrita_linha,
    input  logic [7:0]  escrita_dados,
    output logic        escrita_pronta,
    input  logic        troca_req,
    input  logic        limpar_req,
    output logic        troca_feita,
    input  logic        peca_ativa,
    input  logic        peca_pisca,
    input  logic [15:0] peca_forma,
    input  logic [3:0]  peca_lin,
    input  logic [3:0]  peca_col,
    output logic [7:0]  padrao_linha0,
    output logic [7:0]  padrao_linha1,
    output logic [7:0]  padrao_linha2,
    output logic [7:0]  padrao_linha3,
    output logic [7:0]  padrao_linha4,
    output logic [7:0]  padrao_linha5,
    output logic [7:0]  padrao_linha6,
    output logic [7:0]  padrao_linha7,
    output logic        colisao
);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        COPIA  = 2'd1,
        LIMPA  = 2'd2
    } estado_t;

    estado_t               r_estado;
    logic                  r_ptr;
    logic [2:0]            r_cnt;
    logic [7:0]            r_banco [2][8];
    logic [PISCA_LOG2-1:0] r_pisca;
    logic [7:0]            r_padrao [8];
    logic                  r_colisao;
    logic                  r_feita;

    logic [7:0]            w_frente  [8];
    logic [7:0]            w_overlay [8];
    logic                  w_clip;
    logic                  w_hit;
    logic                  w_vis;
    logic [4:0]            w_lin;
    logic [4:0]            w_col;

    // Piece cells are placed with a 5-bit sum so anything past row/column 7 is clipped.
    always_comb begin
        w_clip = 1'b0;
        w_hit  = 1'b0;
        w_lin  = '0;
        w_col  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_frente[i]  = r_banco[r_ptr][i];
            w_overlay[i] = '0;
        end
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                w_lin = {1'b0, peca_lin} + 5'(r);
                w_col = {1'b0, peca_col} + 5'(j);
                if (peca_forma[4*r+j]) begin
                    if (w_lin[4:3] != 2'b00 || w_col[4:3] != 2'b00) begin
                        w_clip = 1'b1;
                    end else begin
                        w_overlay[w_lin[2:0]][w_col[2:0]] = 1'b1;
                        if (w_frente[w_lin[2:0]][w_col[2:0]]) w_hit = 1'b1;
                    end
                end
            end
        end
    end

    assign w_vis = peca_ativa & (~peca_pisca | ~r_pisca[PISCA_LOG2-1]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 8; i++) r_padrao[i] <= '0;
            r_colisao <= 1'b0;
            r_pisca   <= '0;
        end else begin
            for (int unsigned i = 0; i < 8; i++)
                r_padrao[i] <= w_frente[i] | (w_vis ? w_overlay[i] : 8'h00);
            r_colisao <= peca_ativa & (w_hit | w_clip);
            r_pisca   <= r_pisca + 1'b1;
        end
    end

    // A write coinciding with a swap lands in the outgoing back bank, i.e. the new front.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned b = 0; b < 2; b++)
                for (int unsigned i = 0; i < 8; i++)
                    r_banco[b][i] <= '0;
            r_ptr    <= 1'b0;
            r_cnt    <= '0;
            r_estado <= OCIOSO;
            r_feita  <= 1'b0;
        end else begin
            r_feita <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (escrita_valida) r_banco[~r_ptr][escrita_linha] <= escrita_dados;
                    if (troca_req) begin
                        r_ptr    <= ~r_ptr;
                        r_cnt    <= '0;
                        r_estado <= COPIA;
                    end else if (limpar_req) begin
                        r_cnt    <= '0;
                        r_estado <= LIMPA;
                    end
                end
                COPIA: begin
                    r_banco[~r_ptr][r_cnt] <= r_banco[r_ptr][r_cnt];
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_estado <= OCIOSO;
                        r_feita  <= 1'b1;
                    end
                end
                LIMPA: begin
                    r_banco[~r_ptr][r_cnt] <= '0;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) r_estado <= OCIOSO;
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    assign escrita_pronta = (r_estado == OCIOSO);
    assign troca_feita    = r_feita;
    assign colisao        = r_colisao;
    assign padrao_linha0  = r_padrao[0];
    assign padrao_linha1  = r_padrao[1];
    assign padrao_linha2  = r_padrao[2];
    assign padrao_linha3  = r_padrao[3];
    assign padrao_linha4  = r_padrao[4];
    assign padrao_linha5  = r_padrao[5];
    assign padrao_linha6  = r_padrao[6];
    assign padrao_linha7  = r_padrao[7];

endmodule

// File: tb/tb_quadro_tabuleiro.sv
// Scoreboard bench for quadro_tabuleiro: a bank-level reference model predicts each
// clock's outputs into a queue that an independent monitor drains and compares.
module tb_quadro_tabuleiro;

    localparam int unsigned PL = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        escrita_valida = 1'b0;
    logic [2:0]  escrita_linha = '0;
    logic [7:0]  escrita_dados = '0;
    logic        escrita_pronta;
    logic        troca_req = 1'b0;
    logic        limpar_req = 1'b0;
    logic        troca_feita;
    logic        peca_ativa = 1'b0;
    logic        peca_pisca = 1'b0;
    logic [15:0] peca_forma = '0;
    logic [3:0]  peca_lin = '0;
    logic [3:0]  peca_col = '0;
    logic [7:0]  padrao_linha0, padrao_linha1, padrao_linha2, padrao_linha3;
    logic [7:0]  padrao_linha4, padrao_linha5, padrao_linha6, padrao_linha7;
    logic        colisao;

    always #5 clock = ~clock;

    quadro_tabuleiro #(.PISCA_LOG2(PL)) dut (
        .clock(clock), .reset(reset),
        .escrita_valida(escrita_valida), .escrita_linha(escrita_linha),
        .escrita_dados(escrita_dados), .escrita_pronta(escrita_pronta),
        .troca_req(troca_req), .limpar_req(limpar_req), .troca_feita(troca_feita),
        .peca_ativa(peca_ativa), .peca_pisca(peca_pisca), .peca_forma(peca_forma),
        .peca_lin(peca_lin), .peca_col(peca_col),
        .padrao_linha0(padrao_linha0), .padrao_linha1(padrao_linha1),
        .padrao_linha2(padrao_linha2), .padrao_linha3(padrao_linha3),
        .padrao_linha4(padrao_linha4), .padrao_linha5(padrao_linha5),
        .padrao_linha6(padrao_linha6), .padrao_linha7(padrao_linha7),
        .colisao(colisao)
    );

    typedef struct {
        logic [63:0] pad;
        logic        col;
        logic        feita;
        logic        pronta;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: whole-bank operations; busy time is just a countdown.
    logic [7:0] m_bank [2][8];
    bit         m_ptr;
    int         m_busy;
    bit         m_copy;
    int         m_cyc;

    function automatic logic [63:0] dut_pad();
        return {padrao_linha7, padrao_linha6, padrao_linha5, padrao_linha4,
                padrao_linha3, padrao_linha2, padrao_linha1, padrao_linha0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int b = 0; b < 2; b++)
            for (int n = 0; n < 8; n++) m_bank[b][n] = 8'h00;
        m_ptr  = 0;
        m_busy = 0;
        m_copy = 0;
        m_cyc  = 0;
    endtask

    task automatic step();
        exp_t        e;
        logic [63:0] ov;
        bit          clip, hit, vis;
        int          rr, cc;
        ov   = '0;
        clip = 0;
        hit  = 0;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                if (peca_forma[r*4+j]) begin
                    rr = int'(peca_lin) + r;
                    cc = int'(peca_col) + j;
                    if (rr > 7 || cc > 7) clip = 1;
                    else begin
                        ov[rr*8+cc] = 1'b1;
                        if (m_bank[m_ptr][rr][cc]) hit = 1;
                    end
                end
        vis = peca_ativa && (!peca_pisca || (m_cyc % (1 << PL)) < (1 << (PL - 1)));
        for (int n = 0; n < 8; n++)
            e.pad[n*8 +: 8] = m_bank[m_ptr][n] | (vis ? ov[n*8 +: 8] : 8'h00);
        e.col   = peca_ativa && (hit || clip);
        e.feita = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0 && m_copy) e.feita = 1'b1;
        end else begin
            if (escrita_valida) m_bank[!m_ptr][escrita_linha] = escrita_dados;
            if (troca_req) begin
                m_ptr = !m_ptr;
                for (int n = 0; n < 8; n++) m_bank[!m_ptr][n] = m_bank[m_ptr][n];
                m_busy = 8;
                m_copy = 1;
            end else if (limpar_req) begin
                for (int n = 0; n < 8; n++) m_bank[!m_ptr][n] = 8'h00;
                m_busy = 8;
                m_copy = 0;
            end
        end
        e.pronta = (m_busy == 0);
        m_cyc++;
        q.push_back(e);
    endtask

    task automatic tick();
        step();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_troca();
        troca_req = 1'b1;
        tick();
        troca_req = 1'b0;
    endtask

    task automatic write_row(input logic [2:0] l, input logic [7:0] d);
        escrita_valida = 1'b1;
        escrita_linha  = l;
        escrita_dados  = d;
        tick();
        escrita_valida = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_padrao"}, dut_pad(), 64'h0);
        chk({tag, "_colisao"}, {63'h0, colisao}, 64'h0);
        chk({tag, "_troca_feita"}, {63'h0, troca_feita}, 64'h0);
        chk({tag, "_escrita_pronta"}, {63'h0, escrita_pronta}, 64'h1);
    endtask

    // Monitor: outputs are presented every clock; compare after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int n = 0; n < 8; n++)
                    chk($sformatf("padrao_linha%0d", n),
                        {56'h0, e.pad[n*8 +: 8]} ^ {56'h0, e.pad[n*8 +: 8]} | {56'h0, dut_pad() >> (n*8)} & 64'hFF,
                        {56'h0, e.pad[n*8 +: 8]});
                chk("colisao", {63'h0, colisao}, {63'h0, e.col});
                chk("troca_feita", {63'h0, troca_feita}, {63'h0, e.feita});
                chk("escrita_pronta", {63'h0, escrita_pronta}, {63'h0, e.pronta});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        check_reset_outputs("reset");
        idle(2);

        // Overlay clipping on an empty front bank
        peca_ativa = 1'b1;
        peca_forma = 16'h000F;
        peca_lin   = 4'd7;
        peca_col   = 4'd6;
        idle(2);
        peca_col = 4'd2;
        idle(2);
        peca_ativa = 1'b0;
        idle(1);

        // Write, swap, copy; then a second swap with no writes
        write_row(3'd3, 8'hA5);
        pulse_troca();
        idle(10);
        pulse_troca();
        idle(10);

        // Writes and swap requests during COPIA are ignored
        pulse_troca();
        escrita_valida = 1'b1;
        escrita_linha  = 3'd0;
        escrita_dados  = 8'hFF;
        troca_req      = 1'b1;
        tick();
        escrita_valida = 1'b0;
        troca_req      = 1'b0;
        idle(9);
        pulse_troca();
        idle(10);

        // Collision against a settled cell, with blinking
        write_row(3'd5, 8'h10);
        pulse_troca();
        idle(10);
        peca_ativa = 1'b1;
        peca_forma = 16'h0001;
        peca_lin   = 4'd5;
        peca_col   = 4'd4;
        idle(3);
        peca_pisca = 1'b1;
        idle(16);
        peca_pisca = 1'b0;
        peca_ativa = 1'b0;

        // Swap and clear together: swap wins
        troca_req  = 1'b1;
        limpar_req = 1'b1;
        tick();
        troca_req  = 1'b0;
        limpar_req = 1'b0;
        idle(10);
        pulse_troca();
        idle(10);
        limpar_req = 1'b1;
        tick();
        limpar_req = 1'b0;
        idle(10);
        pulse_troca();
        idle(10);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            escrita_valida = ($urandom_range(0, 1) == 1);
            escrita_linha  = 3'($urandom_range(0, 7));
            escrita_dados  = 8'($urandom_range(0, 255));
            troca_req      = ($urandom_range(0, 9) == 0);
            limpar_req     = ($urandom_range(0, 11) == 0);
            peca_ativa     = ($urandom_range(0, 9) < 7);
            peca_pisca     = ($urandom_range(0, 9) < 3);
            peca_forma     = 16'($urandom_range(0, 65535));
            peca_lin       = 4'($urandom_range(0, 9));
            peca_col       = 4'($urandom_range(0, 9));
            tick();
        end
        escrita_valida = 1'b0;
        troca_req      = 1'b0;
        limpar_req     = 1'b0;
        peca_ativa     = 1'b0;
        peca_pisca     = 1'b0;
        idle(10);

        // Reset on the 4th COPIA cycle
        write_row(3'd1, 8'h3C);
        pulse_troca();
        idle(3);
        reset = 1'b0;
        #1;
        check_reset_outputs("midcopy_reset");
        m_reset();
        @(negedge clock);
        reset = 1'b1;
        idle(12);

        repeat (2) @(negedge clock);
        chk("scoreboard_drained", 64'(q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
